// File: rtl/mem_access_seq.sv
// mem_access_seq: memory-stage load/store sequencer (plain read, read-modify-write, direct write).
// Define MEM_MISALIGN_TRAP_EN to add the misalign output and trap misaligned half/word accesses.
module mem_access_seq #(
    parameter int MEM_LAT = 1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] mem_addr,
    output logic        mem_wr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic [31:0] merge_word,
    output logic [1:0]  ls_sel,
    input  logic [31:0] merged_in,
    output logic [31:0] load_data,
    output logic        busy,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    output logic        done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_MRG,
        S_MCAP,
        S_WR,
        S_DONE
    } state_t;

    localparam logic [1:0] SZ_NOP  = 2'b00;
    localparam logic [1:0] SZ_BYTE = 2'b01;
    localparam logic [1:0] SZ_HALF = 2'b10;
    localparam logic [1:0] SZ_WORD = 2'b11;

    state_t      state;
    logic [2:0]  cnt_q;
    logic        is_store_q;
    logic [1:0]  size_q;
    logic        unsigned_q;
    logic [29:0] word_addr_q;
    logic [31:0] word_q;
    logic        misaligned_start;

    // Loads always take the low lane of the fetched word.
    function automatic logic [31:0] extend_load(input logic [31:0] word,
                                                input logic [1:0]  sz,
                                                input logic        zero_ext);
        logic [31:0] res;
        case (sz)
            SZ_BYTE: res = {{24{~zero_ext & word[7]}}, word[7:0]};
            SZ_HALF: res = {{16{~zero_ext & word[15]}}, word[15:0]};
            default: res = word;
        endcase
        return res;
    endfunction

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned_start = ((size == SZ_HALF) && addr[0]) ||
                              ((size == SZ_WORD) && (addr[1:0] != 2'b00));
`else
    logic unused_addr_lsbs;
    assign misaligned_start = 1'b0;
    assign unused_addr_lsbs = ^addr[1:0];
`endif

    assign merge_word = word_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= S_IDLE;
            cnt_q       <= 3'd0;
            is_store_q  <= 1'b0;
            size_q      <= SZ_NOP;
            unsigned_q  <= 1'b0;
            word_addr_q <= 30'd0;
            word_q      <= 32'd0;
            mem_addr    <= 32'd0;
            mem_wr      <= 1'b0;
            mem_wdata   <= 32'd0;
            ls_sel      <= SZ_NOP;
            load_data   <= 32'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign    <= 1'b0;
`endif
        end else begin
            // NOTE: single-cycle strobes default low here with non-blocking assignments;
            // the state arms below override them for the one cycle they must be high.
            mem_wr <= 1'b0;
            ls_sel <= SZ_NOP;
            done   <= 1'b0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign <= 1'b0;
`endif
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_store_q  <= is_store;
                        size_q      <= size;
                        unsigned_q  <= load_unsigned;
                        word_addr_q <= addr[31:2];
                        busy        <= 1'b1;
                        if ((size == SZ_NOP) || misaligned_start) begin
                            state <= S_DONE;
                            done  <= 1'b1;
`ifdef MEM_MISALIGN_TRAP_EN
                            misalign <= misaligned_start;
`endif
                        end else if (is_store && (size == SZ_WORD)) begin
                            state     <= S_WR;
                            mem_wr    <= 1'b1;
                            mem_addr  <= {addr[31:2], 2'b00};
                            mem_wdata <= wdata;
                        end else begin
                            state    <= S_RD;
                            mem_addr <= {addr[31:2], 2'b00};
                            cnt_q    <= 3'(MEM_LAT - 1);
                        end
                    end
                end
                S_RD: begin
                    if (cnt_q == 3'd0) begin
                        word_q <= mem_rdata;
                        if (is_store_q) begin
                            state  <= S_MRG;
                            ls_sel <= size_q;
                        end else begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            load_data <= extend_load(mem_rdata, size_q, unsigned_q);
                        end
                    end else begin
                        cnt_q <= cnt_q - 3'd1;
                    end
                end
                S_MRG: state <= S_MCAP;
                // The merge stage output is registered, so it is only valid during MCAP.
                S_MCAP: begin
                    state     <= S_WR;
                    mem_wr    <= 1'b1;
                    mem_wdata <= merged_in;
                    mem_addr  <= {word_addr_q, 2'b00};
                end
                S_WR: begin
                    state <= S_DONE;
                    done  <= 1'b1;
                end
                S_DONE: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_seq.sv
// Bench for mem_access_seq: two instances (MEM_LAT=1 and 3) run the same directed requests,
// with a scoreboard of expected merge/write/done events per instance.
module tb_mem_access_seq;

    localparam int K_MERGE = 1;
    localparam int K_WR    = 2;
    localparam int K_DONE  = 3;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    typedef struct {
        int          dut;
        int          kind;
        int          k;
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  m;
    } ev_t;

    logic        clock = 1'b0;
    logic [1:0]  reset_i;
    logic [1:0]  start_i;
    logic        is_store;
    logic [1:0]  size;
    logic        load_unsigned;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem_rdata_i  [2];
    logic [31:0] merged_in_i  [2];
    logic [31:0] mem_addr_o   [2];
    logic [31:0] mem_wdata_o  [2];
    logic [31:0] merge_word_o [2];
    logic [31:0] load_data_o  [2];
    logic [1:0]  ls_sel_o     [2];
    logic        mem_wr_o     [2];
    logic        busy_o       [2];
    logic        done_o       [2];
    logic        misalign_o   [2];

    ev_t         sb[$];
    int          n_cmp = 0;
    int          n_err = 0;
    logic [31:0] ld_model = 32'd0;
    logic [31:0] addr_model = 32'd0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_access_seq #(.MEM_LAT(g == 0 ? 1 : 3)) u_dut (
            .clock        (clock),
            .reset        (reset_i[g]),
            .start        (start_i[g]),
            .is_store     (is_store),
            .size         (size),
            .load_unsigned(load_unsigned),
            .addr         (addr),
            .wdata        (wdata),
            .mem_addr     (mem_addr_o[g]),
            .mem_wr       (mem_wr_o[g]),
            .mem_wdata    (mem_wdata_o[g]),
            .mem_rdata    (mem_rdata_i[g]),
            .merge_word   (merge_word_o[g]),
            .ls_sel       (ls_sel_o[g]),
            .merged_in    (merged_in_i[g]),
            .load_data    (load_data_o[g]),
            .busy         (busy_o[g]),
`ifdef MEM_MISALIGN_TRAP_EN
            .misalign     (misalign_o[g]),
`endif
            .done         (done_o[g])
        );
`ifndef MEM_MISALIGN_TRAP_EN
        assign misalign_o[g] = 1'b0;
`endif
    end

    function automatic int lat(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] merge_ref(input logic [31:0] w, input logic [31:0] d,
                                              input logic [1:0] sel, input logic [1:0] off);
        logic [31:0] r;
        r = w;
        case (sel)
            2'b01:   r[8*off +: 8] = d[7:0];
            2'b10:   r[16*off[1] +: 16] = d[15:0];
            default: r = d;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] extract_ref(input logic [31:0] w, input logic [1:0] sz,
                                                input logic uns);
        case (sz)
            2'b01:   return uns ? {24'h0, w[7:0]} : {{24{w[7]}}, w[7:0]};
            2'b10:   return uns ? {16'h0, w[15:0]} : {{16{w[15]}}, w[15:0]};
            default: return w;
        endcase
    endfunction

    function automatic logic mis_ref(input logic [1:0] sz, input logic [31:0] a);
        return TRAP && (((sz == 2'b10) && a[0]) || ((sz == 2'b11) && (a[1:0] != 2'b00)));
    endfunction

    function automatic logic [159:0] pack_state(input int i);
        return {26'd0, mem_addr_o[i], mem_wdata_o[i], load_data_o[i], merge_word_o[i],
                busy_o[i], done_o[i], mem_wr_o[i], ls_sel_o[i], misalign_o[i]};
    endfunction

    // Merge-stage model: registers the merged word while ls_sel is non-zero, holds otherwise.
    always @(posedge clock)
        for (int i = 0; i < 2; i++)
            if (ls_sel_o[i] != 2'b00)
                merged_in_i[i] <= merge_ref(merge_word_o[i], wdata, ls_sel_o[i], addr[1:0]);

    task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
        end
    endtask

    task automatic observe(input int i, input int kind, input int k, input logic [31:0] a,
                           input logic [31:0] d, input logic [1:0] m);
        int  idx;
        ev_t e;
        idx = -1;
        for (int j = 0; j < sb.size(); j++)
            if (sb[j].dut == i) begin
                idx = j;
                break;
            end
        if (idx < 0) begin
            check($sformatf("dut%0d unexpected event", i),
                  {30'd0, m, 32'(kind), 32'(k), a, d}, 160'd0);
        end else begin
            e = sb[idx];
            sb.delete(idx);
            check($sformatf("dut%0d kind%0d cycle%0d", i, e.kind, e.k),
                  {30'd0, m, 32'(kind), 32'(k), a, d},
                  {30'd0, e.m, 32'(e.kind), 32'(e.k), e.a, e.d});
        end
    endtask

    task automatic sample(input int k);
        for (int i = 0; i < 2; i++) begin
            if (ls_sel_o[i] != 2'b00)
                observe(i, K_MERGE, k, {30'd0, ls_sel_o[i]}, merge_word_o[i], 2'b00);
            if (mem_wr_o[i])
                observe(i, K_WR, k, mem_addr_o[i], mem_wdata_o[i], 2'b00);
            if (done_o[i])
                observe(i, K_DONE, k, mem_addr_o[i], load_data_o[i], {misalign_o[i], busy_o[i]});
        end
    endtask

    // mode: 0 single request, 1 start held through a load (back-to-back), 2 reset during MRG
    task automatic run_req(input logic st, input logic [1:0] sz, input logic uns,
                           input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] rdata, input int mode);
        logic        mis;
        logic [31:0] al;
        logic [31:0] nld;
        int          k;
        int          extra;
        int          ln;
        ev_t         e;
        mis = mis_ref(sz, a);
        al  = {a[31:2], 2'b00};
        nld = extract_ref(rdata, sz, uns);
        is_store = st;
        size = sz;
        load_unsigned = uns;
        addr = a;
        wdata = d;
        for (int i = 0; i < 2; i++) begin
            ln = lat(i);
            if ((sz == 2'b00) || mis) begin
                sb.push_back(ev_t'{i, K_DONE, 0, addr_model, ld_model, {mis, 1'b1}});
            end else if (!st) begin
                sb.push_back(ev_t'{i, K_DONE, ln, al, nld, 2'b01});
                if (mode == 1) sb.push_back(ev_t'{i, K_DONE, 2*ln + 2, al, nld, 2'b01});
            end else if (sz == 2'b11) begin
                sb.push_back(ev_t'{i, K_WR, 0, al, d, 2'b00});
                sb.push_back(ev_t'{i, K_DONE, 1, al, ld_model, 2'b01});
            end else begin
                sb.push_back(ev_t'{i, K_MERGE, ln, {30'd0, sz}, rdata, 2'b00});
                if (mode != 2) begin
                    sb.push_back(ev_t'{i, K_WR, ln + 2, al, merge_ref(rdata, d, sz, a[1:0]), 2'b00});
                    sb.push_back(ev_t'{i, K_DONE, ln + 3, al, ld_model, 2'b01});
                end
            end
        end
        if ((sz != 2'b00) && !mis) addr_model = al;
        if ((sz != 2'b00) && !mis && !st) ld_model = nld;
        if (mode == 2) begin
            addr_model = 32'd0;
            ld_model = 32'd0;
        end

        start_i = 2'b11;
        k = 0;
        extra = 0;
        while ((k < 40) && ((sb.size() != 0) || (extra < 4))) begin
            for (int i = 0; i < 2; i++)
                mem_rdata_i[i] = ((k == lat(i)) || ((mode == 1) && (k == 2*lat(i) + 2))) ? rdata : ~rdata;
            @(posedge clock);
            #1;
            sample(k);
            for (int i = 0; i < 2; i++) begin
                if (k == ((mode == 1) ? lat(i) + 2 : 0)) start_i[i] = 1'b0;
                if (reset_i[i]) begin
                    check($sformatf("dut%0d state after reset in MRG", i), pack_state(i), 160'd0);
                    reset_i[i] = 1'b0;
                end else if ((mode == 2) && (ls_sel_o[i] != 2'b00)) begin
                    reset_i[i] = 1'b1;
                end
            end
            if (sb.size() == 0) extra++;
            k++;
        end
        start_i = 2'b00;
        while (sb.size() != 0) begin
            e = sb.pop_front();
            check($sformatf("dut%0d missed kind%0d cycle%0d", e.dut, e.kind, e.k),
                  160'd0, {30'd0, e.m, 32'(e.kind), 32'(e.k), e.a, e.d});
        end
        for (int i = 0; i < 2; i++)
            check($sformatf("dut%0d idle after request", i),
                  {155'd0, busy_o[i], done_o[i], mem_wr_o[i], ls_sel_o[i], misalign_o[i]}, 160'd0);
    endtask

    initial begin
        reset_i = 2'b11;
        start_i = 2'b00;
        is_store = 1'b0;
        size = 2'b00;
        load_unsigned = 1'b0;
        addr = 32'd0;
        wdata = 32'd0;
        mem_rdata_i[0] = 32'd0;
        mem_rdata_i[1] = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < 2; i++)
            check($sformatf("dut%0d reset state", i), pack_state(i), 160'd0);
        reset_i = 2'b00;

        run_req(1'b0, 2'b01, 1'b0, 32'h0000_0100, 32'h0, 32'h0000_00F0, 0);           // lb  -> FFFFFFF0
        run_req(1'b0, 2'b10, 1'b1, 32'h0000_0202, 32'h0, 32'h1234_ABCD, 0);           // lhu -> 0000ABCD
        run_req(1'b0, 2'b10, 1'b0, 32'h0000_0204, 32'h0, 32'h0000_8001, 0);           // lh  -> FFFF8001
        run_req(1'b0, 2'b01, 1'b1, 32'h0000_0105, 32'h0, 32'h7FFF_FF9C, 0);           // lbu -> 0000009C
        run_req(1'b0, 2'b11, 1'b0, 32'h0000_0308, 32'h0, 32'h8000_0001, 0);           // lw
        run_req(1'b1, 2'b11, 1'b0, 32'h0000_0040, 32'hDEAD_BEEF, 32'h0, 0);           // sw
        run_req(1'b1, 2'b01, 1'b0, 32'h0000_0043, 32'h0000_00AA, 32'h1122_3344, 0);   // sb -> AA223344
        run_req(1'b1, 2'b10, 1'b0, 32'h0000_0082, 32'hCAFE_5566, 32'h1122_3344, 0);   // sh -> 55663344
        run_req(1'b1, 2'b00, 1'b0, 32'h0000_0500, 32'h0000_0001, 32'h0, 0);           // no-op
        run_req(1'b0, 2'b01, 1'b0, 32'h0000_0104, 32'h0, 32'h0000_0081, 1);           // start held high
        run_req(1'b1, 2'b01, 1'b0, 32'h0000_0061, 32'h0000_0077, 32'hA5A5_A5A5, 2);   // reset in MRG
        run_req(1'b0, 2'b11, 1'b0, 32'h0000_0042, 32'h0, 32'h0BAD_F00D, 0);           // lw at 0x42
        run_req(1'b1, 2'b10, 1'b0, 32'h0000_0081, 32'h0000_1234, 32'h5555_5555, 0);   // sh at odd address

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
